// File: rtl/bnn_pkg.sv
// Shared constants, state codes and SRAM control helpers for the BNN instruction loader.
package bnn_pkg;

  localparam int INST_AW       = 11;
  localparam int INST_DW       = 16;
  localparam int ISRAM_CTRL_W  = 13;
  localparam int ISRAM_CEN_BIT = 11;
  localparam int ISRAM_WEN_BIT = 12;

  localparam logic [ISRAM_CTRL_W-1:0] ISRAM_IDLE = 13'h1800;

  typedef logic [2:0] bnn_state_t;

  localparam bnn_state_t ST_IDLE    = 3'd0;
  localparam bnn_state_t ST_LEN     = 3'd1;
  localparam bnn_state_t ST_DATA    = 3'd2;
  localparam bnn_state_t ST_CHK     = 3'd3;
  localparam bnn_state_t ST_RELEASE = 3'd4;
  localparam bnn_state_t ST_RUN     = 3'd5;
  localparam bnn_state_t ST_ERR     = 3'd6;

  // Control word for a single write: both strobes low, address in the low bits.
  function automatic logic [ISRAM_CTRL_W-1:0] isram_write(input logic [INST_AW-1:0] addr);
    logic [ISRAM_CTRL_W-1:0] c;
    c                = ISRAM_IDLE;
    c[ISRAM_CEN_BIT] = 1'b0;
    c[ISRAM_WEN_BIT] = 1'b0;
    c[INST_AW-1:0]   = addr;
    return c;
  endfunction

endpackage

// File: rtl/bnn_isram_mux.sv
// Instruction SRAM port select: the BNN controller owns the port in RUN, the loader otherwise.
module bnn_isram_mux
  import bnn_pkg::*;
(
  input  logic                    sel_run,
  input  logic [ISRAM_CTRL_W-1:0] ctrl_isram,
  input  logic [ISRAM_CTRL_W-1:0] ldr_ctrl,
  input  logic [INST_DW-1:0]      ldr_din,
  output logic [ISRAM_CTRL_W-1:0] instsram_ctrl,
  output logic [INST_DW-1:0]      instsram_din
);

  assign instsram_ctrl = sel_run ? ctrl_isram : ldr_ctrl;
  assign instsram_din  = sel_run ? '0 : ldr_din;

endmodule

// File: rtl/bnn_inst_loader.sv
// Loads a length-prefixed instruction stream into the BNN instruction SRAM, then releases the controller.
// Optional trailer checksum (16-bit XOR of all words) enabled by defining BNN_LOADER_VERIFY_EN.
module bnn_inst_loader
  import bnn_pkg::*;
#(
  parameter int unsigned INST_DEPTH = 2048,
  parameter int unsigned MAX_LEN    = INST_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [INST_DW-1:0]      host_data,
  input  logic                    host_valid,
  output logic                    host_ready,
  input  logic [ISRAM_CTRL_W-1:0] ctrl_isram,
  output logic [ISRAM_CTRL_W-1:0] instsram_ctrl,
  output logic [INST_DW-1:0]      instsram_din,
  output logic                    ctrl_rst,
  output logic                    ctrl_pause,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  bnn_state_t               state, state_nxt;
  logic [11:0]              n_len;
  logic [11:0]              cnt;
  logic                     rel_cnt;
  logic [ISRAM_CTRL_W-1:0]  wr_ctrl;
  logic [INST_DW-1:0]       wr_din;
  logic                     hs;
  logic                     len_bad;
  logic                     last_word;

`ifdef BNN_LOADER_VERIFY_EN
  logic [INST_DW-1:0]       csum;
`endif

  assign host_ready = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CHK);
  assign hs         = host_valid & host_ready;
  assign busy       = host_ready || (state == ST_RELEASE);
  assign done       = (state == ST_RUN);
  assign err        = (state == ST_ERR);
  assign ctrl_rst   = (state != ST_RUN);
  assign ctrl_pause = (state != ST_RUN);

  assign len_bad   = (host_data[11:0] == '0) || (host_data[15:12] != '0) ||
                     (32'(host_data[11:0]) > MAX_LEN);
  assign last_word = (cnt + 12'd1) == n_len;

  // NOTE: always_comb starts from a full default so no path can leave state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (start) state_nxt = ST_LEN;
      ST_LEN:     if (hs) state_nxt = len_bad ? ST_ERR : ST_DATA;
      ST_DATA: begin
        if (hs && last_word) begin
`ifdef BNN_LOADER_VERIFY_EN
          state_nxt = ST_CHK;
`else
          state_nxt = ST_RELEASE;
`endif
        end
      end
`ifdef BNN_LOADER_VERIFY_EN
      ST_CHK:     if (hs) state_nxt = (host_data == csum) ? ST_RELEASE : ST_ERR;
`endif
      ST_RELEASE: if (rel_cnt) state_nxt = ST_RUN;
      ST_RUN,
      ST_ERR:     if (start) state_nxt = ST_LEN;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      n_len   <= '0;
      cnt     <= '0;
      rel_cnt <= 1'b0;
      wr_ctrl <= ISRAM_IDLE;
      wr_din  <= '0;
    end else begin
      state   <= state_nxt;
      rel_cnt <= (state == ST_RELEASE) && !rel_cnt;
      // The write port returns to idle unless a word was accepted on this edge.
      wr_ctrl <= ISRAM_IDLE;
      wr_din  <= '0;
      if (state == ST_LEN && hs) begin
        n_len <= host_data[11:0];
        cnt   <= '0;
      end
      if (state == ST_DATA && hs) begin
        wr_ctrl <= isram_write(cnt[INST_AW-1:0]);
        wr_din  <= host_data;
        cnt     <= cnt + 12'd1;
      end
    end
  end

`ifdef BNN_LOADER_VERIFY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum <= '0;
    end else if (state == ST_LEN && hs) begin
      csum <= '0;
    end else if (state == ST_DATA && hs) begin
      csum <= csum ^ host_data;
    end
  end
`endif

  bnn_isram_mux u_mux (
    .sel_run       (state == ST_RUN),
    .ctrl_isram    (ctrl_isram),
    .ldr_ctrl      (wr_ctrl),
    .ldr_din       (wr_din),
    .instsram_ctrl (instsram_ctrl),
    .instsram_din  (instsram_din)
  );

endmodule

// File: tb/tb_bnn_inst_loader.sv
// Self-checking bench for bnn_inst_loader: protocol-level model, per-cycle compare, directed loads.
module tb_bnn_inst_loader;

`ifdef BNN_LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int MODEL_MAX = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] host_data = '0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic [12:0] ctrl_isram = 13'h1800;
  logic [12:0] instsram_ctrl;
  logic [15:0] instsram_din;
  logic        ctrl_rst, ctrl_pause, busy, done, err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bnn_inst_loader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .host_data     (host_data),
    .host_valid    (host_valid),
    .host_ready    (host_ready),
    .ctrl_isram    (ctrl_isram),
    .instsram_ctrl (instsram_ctrl),
    .instsram_din  (instsram_din),
    .ctrl_rst      (ctrl_rst),
    .ctrl_pause    (ctrl_pause),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Protocol model: which phase the loader is in, words still owed, and the write due this cycle.
  typedef enum int {P_IDLE, P_LEN, P_DATA, P_CHK, P_REL, P_RUN, P_ERR} phase_t;
  phase_t      m_phase = P_IDLE;
  int          m_left = 0;
  int          m_addr = 0;
  int          m_rel = 0;
  int          m_len;
  logic [15:0] m_xor = '0;
  bit          m_wr = 1'b0;
  logic [10:0] m_wa = '0;
  logic [15:0] m_wd = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase = P_IDLE; m_left = 0; m_addr = 0; m_rel = 0; m_xor = '0;
      m_wr = 1'b0; m_wa = '0; m_wd = '0;
    end else begin
      m_wr = 1'b0; m_wa = '0; m_wd = '0;
      case (m_phase)
        P_IDLE: if (start) m_phase = P_LEN;
        P_LEN: if (host_valid) begin
          m_len = int'(host_data);
          if (m_len == 0 || m_len > MODEL_MAX) m_phase = P_ERR;
          else begin m_left = m_len; m_addr = 0; m_xor = '0; m_phase = P_DATA; end
        end
        P_DATA: if (host_valid) begin
          m_wr = 1'b1; m_wa = 11'(m_addr); m_wd = host_data;
          m_addr++; m_xor ^= host_data; m_left--;
          if (m_left == 0) begin m_phase = VERIFY ? P_CHK : P_REL; m_rel = 2; end
        end
        P_CHK: if (host_valid) m_phase = (host_data == m_xor) ? P_REL : P_ERR;
        P_REL: begin m_rel--; if (m_rel == 0) m_phase = P_RUN; end
        P_RUN, P_ERR: if (start) m_phase = P_LEN;
        default: m_phase = P_IDLE;
      endcase
    end
  end

  typedef struct { int c; logic [10:0] a; logic [15:0] d; } wr_t;
  wr_t         wlog[$];
  logic [12:0] exp_ctrl;
  logic [15:0] exp_din;
  bit          in_run;

  always @(negedge clk) begin
    in_run   = (m_phase == P_RUN);
    exp_ctrl = in_run ? ctrl_isram : (m_wr ? {2'b00, m_wa} : 13'h1800);
    exp_din  = (!in_run && m_wr) ? m_wd : 16'h0000;
    check("host_ready", host_ready, m_phase inside {P_LEN, P_DATA, P_CHK});
    check("busy", busy, m_phase inside {P_LEN, P_DATA, P_CHK, P_REL});
    check("done", done, in_run);
    check("err", err, m_phase == P_ERR);
    check("ctrl_rst", ctrl_rst, !in_run);
    check("ctrl_pause", ctrl_pause, !in_run);
    check("instsram_ctrl", instsram_ctrl, exp_ctrl);
    check("instsram_din", instsram_din, exp_din);
    if (rst && !done && !instsram_ctrl[11]) wlog.push_back('{cyc, instsram_ctrl[10:0], instsram_din});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] w);
    host_valid = 1'b1;
    host_data  = w;
    tick();
    host_valid = 1'b0;
  endtask

  task automatic send_trailer(input logic [15:0] x);
    if (VERIFY) send(x);
  endtask

  task automatic wait_done(output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin c = cyc; break; end
    end
    check("reach_run", done, 1'b1);
  endtask

  task automatic check_log(input string tag, input int n, input int step,
                           input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w3);
    logic [15:0] ws [4];
    ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
    check({tag, "_nwrites"}, wlog.size(), n);
    for (int i = 0; i < wlog.size() && i < n; i++) begin
      check({tag, "_addr"}, wlog[i].a, i);
      check({tag, "_data"}, wlog[i].d, ws[i]);
      if (i > 0) check({tag, "_spacing"}, wlog[i].c - wlog[i-1].c, step);
    end
  endtask

  int run_c;

  initial begin
    #2 rst = 1'b0;
    #1;
    check("rst_ctrl", instsram_ctrl, 13'h1800);
    check("rst_ctrl_rst", ctrl_rst, 1'b1);
    check("rst_busy", busy, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Back-to-back 3-word load, then controller owns the SRAM port.
    wlog.delete();
    pulse_start();
    send(16'd3);
    send(16'h0801); send(16'h2081); send(16'h3005);
    send_trailer(16'h0801 ^ 16'h2081 ^ 16'h3005);
    wait_done(run_c);
    check_log("b2b", 3, 1, 16'h0801, 16'h2081, 16'h3005, 16'h0000);
    if (wlog.size() == 3) check("b2b_release_gap", run_c - wlog[2].c, VERIFY ? 3 : 2);
    ctrl_isram = 13'h1005;
    #1;
    check("run_passthru", instsram_ctrl, 13'h1005);
    check("run_din", instsram_din, 16'h0000);
    check("run_ctrl_rst", ctrl_rst, 1'b0);
    tick();
    ctrl_isram = 13'h1800;

    // Restart from RUN, then two illegal lengths.
    wlog.delete();
    pulse_start();
    check("restart_ctrl_rst", ctrl_rst, 1'b1);
    check("restart_done", done, 1'b0);
    check("restart_busy", busy, 1'b1);
    send(16'h0000);
    check("len0_err", err, 1'b1);
    check("len0_pause", ctrl_pause, 1'b1);
    pulse_start();
    check("err_cleared", err, 1'b0);
    send(16'h0801);
    check("len2049_err", err, 1'b1);
    check("len2049_ready", host_ready, 1'b0);
    send(16'h0001);
    tick();
    check("err_nowrite", wlog.size(), 0);
    check("err_sticky", err, 1'b1);

    // 4-word load with host_valid gaps.
    wlog.delete();
    pulse_start();
    send(16'd4);
    send(16'h1111); tick();
    send(16'h2222); tick();
    send(16'h4444); tick();
    send(16'h8888);
    send_trailer(16'hFFFF);
    wait_done(run_c);
    check_log("gap", 4, 2, 16'h1111, 16'h2222, 16'h4444, 16'h8888);

    // start during DATA is ignored.
    wlog.delete();
    pulse_start();
    send(16'd2);
    send(16'hAAAA);
    pulse_start();
    check("start_in_data_busy", busy, 1'b1);
    send(16'h5555);
    send_trailer(16'hFFFF);
    wait_done(run_c);
    check_log("ign", 2, 2, 16'hAAAA, 16'h5555, 16'h0000, 16'h0000);

    // Reset after 2 of 5 words, then a clean reload.
    pulse_start();
    send(16'd5);
    send(16'h0123); send(16'h4567);
    rst = 1'b0;
    #1;
    check("abort_ctrl", instsram_ctrl, 13'h1800);
    check("abort_din", instsram_din, 16'h0000);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", host_ready, 1'b0);
    check("abort_ctrl_rst", ctrl_rst, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    wlog.delete();
    pulse_start();
    send(16'd2);
    send(16'hBEEF); send(16'hCAFE);
    send_trailer(16'hBEEF ^ 16'hCAFE);
    wait_done(run_c);
    check_log("reload", 2, 1, 16'hBEEF, 16'hCAFE, 16'h0000, 16'h0000);

`ifdef BNN_LOADER_VERIFY_EN
    pulse_start();
    send(16'd2);
    send(16'h00F0); send(16'h0F00); send(16'h0FF0);
    wait_done(run_c);
    pulse_start();
    send(16'd2);
    send(16'h00F0); send(16'h0F00); send(16'h0FF1);
    check("bad_trailer_err", err, 1'b1);
    check("bad_trailer_done", done, 1'b0);
`endif

    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bnn_inst_loader.md
BNN_INST_LOADER -- requirements
Module: bnn_inst_loader

Interface
REQ-001 SHALL expose parameter INST_DEPTH, default 2048, the instruction SRAM depth in words; the address width is 11 bits.
REQ-002 SHALL expose parameter MAX_LEN, default INST_DEPTH, the largest accepted program length.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low.
REQ-005 start  in  1  one-cycle pulse that begins a program load.
REQ-006 host_data  in  16  instruction stream word.
REQ-007 host_valid  in  1  host_data is valid.
REQ-008 host_ready  out  1  the loader accepts host_data this cycle.
REQ-009 ctrl_isram  in  13  SRAM control from the BNN controller: [10:0] address, [11] CEN (active-low), [12] WEN (active-low).
REQ-010 instsram_ctrl  out  13  SRAM control to the instruction SRAM, same format as ctrl_isram.
REQ-011 instsram_din  out  16  SRAM write data.
REQ-012 ctrl_rst  out  1  synchronous active-high reset to the BNN controller.
REQ-013 ctrl_pause  out  1  pause to the BNN controller.
REQ-014 busy, done, err  out  1 each  status levels.

Function
REQ-015 SHALL implement the states IDLE, LEN, DATA, CHK, RELEASE, RUN and ERR.
REQ-016 IDLE:
- start moves to LEN.
- all other inputs are ignored.
REQ-017 LEN:
- host_ready=1.
- On handshake, host_data[11:0] is latched as N.
- N=0, or N>MAX_LEN, or host_data[15:12]!=0, moves to ERR.
- Any other value moves to DATA with the address counter at 0.
REQ-018 DATA:
- host_ready=1.
- Each handshake (host_valid & host_ready) registers one write.
- The cycle after a handshake: instsram_ctrl={WEN=0,CEN=0,addr}, instsram_din=word.
- The address then increments.
- Throughput is one word per cycle with no bubbles; a host_valid gap produces an idle cycle with CEN=1.
REQ-019 After handshake number N, DATA SHALL move to CHK when BNN_LOADER_VERIFY_EN is defined, otherwise to RELEASE.
REQ-020 RELEASE SHALL hold ctrl_rst=1 and ctrl_pause=1 for exactly 2 cycles, then move to RUN.
REQ-021 RUN:
- ctrl_rst=0, ctrl_pause=0, done=1.
- instsram_ctrl=ctrl_isram, passed combinationally.
- instsram_din=0.
REQ-022 In every state except RUN, instsram_ctrl SHALL be driven by the loader; when not writing its idle value is 13'h1800 (WEN=1, CEN=1, address 0).
REQ-023 ctrl_rst=1 and ctrl_pause=1 SHALL hold in every state except RUN.
REQ-024 busy=1 in LEN, DATA, CHK and RELEASE.
REQ-025 start while busy SHALL be ignored.
REQ-026 start in RUN or ERR SHALL move to LEN and clear done and err.
REQ-027 ERR:
- err=1, host_ready=0.
- Outputs are held as in IDLE.
- Exit only via start or reset.
REQ-028 Words sent while host_ready=0 SHALL not be consumed.
REQ-029 The address counter is 12 bits; the write address is counter[10:0]; N=2048 writes addresses 0..2047 without wrap.

Reset
REQ-030 SHALL apply the following values while rst=0:
- state=IDLE
- host_ready=0
- instsram_ctrl=13'h1800, instsram_din=0
- ctrl_rst=1, ctrl_pause=1
- busy=0, done=0, err=0
- N=0, address counter 0, checksum 0
REQ-031 Reset asserted mid-load SHALL abort immediately; SRAM contents are undefined afterwards and a new start is required.

Configuration
REQ-032 BNN_LOADER_VERIFY_EN defined:
- A 16-bit running XOR of all N data words is kept.
- CHK accepts one trailer word with host_ready=1.
- A match moves to RELEASE; a mismatch moves to ERR.
REQ-033 BNN_LOADER_VERIFY_EN undefined:
- There is no CHK state and no checksum register.
- No trailer word is expected.

Structure
REQ-034 A shared package bnn_pkg SHALL hold:
- the state enumeration
- constants INST_AW=11, ISRAM_CEN_BIT=11, ISRAM_WEN_BIT=12, ISRAM_IDLE=13'h1800
REQ-035 SHALL contain one natural sub-module, bnn_isram_mux: the RUN-versus-loader SRAM port select.

Verification
REQ-036 start, then length 3 and words 16'h0801, 16'h2081, 16'h3005 sent back-to-back:
- writes occur at addresses 0, 1 and 2 on 3 consecutive cycles;
- 2 cycles of ctrl_rst follow;
- then RUN, with ctrl_isram=13'h1005 visible on instsram_ctrl.
REQ-037 Length word 0, and separately 16'h0801 (2049):
- err=1, ctrl_pause=1, no SRAM write.
REQ-038 host_valid toggling every other cycle during a 4-word load:
- 4 writes, each one cycle after its handshake, with CEN=1 in the gap cycles.
REQ-039 Reset asserted after 2 of 5 words:
- all outputs at reset values in the same cycle;
- a later start loads cleanly.
REQ-040 With BNN_LOADER_VERIFY_EN: words 16'h00F0, 16'h0F00 with trailer 16'h0FF0 reach RUN; with trailer 16'h0FF1, err=1.
REQ-041 start during DATA is ignored; start in RUN re-enters LEN, ctrl_rst=1 the next cycle.
